imm_rs_rt_encoder: RTL and testbench
====================================

# imm_rs_rt_encoder

Encodes a 32-bit immediate into the 6-bit rs/rt register fields of a 32-bit instruction word for the instruction-memory loader path. Each accepted request carries an opcode, rd and immediate. The block emits one packed instruction through a 2-entry output buffer with a valid/ready handshake, with optional range checking. The decode side recovers the immediate as zero-extended {rs, rt}, so the encode/decode round trip is lossless for immediates 0..4095.

## Interface
- No parameters; all widths are fixed by the ISA.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_imm  input  32  immediate to encode
- in_opcode  input  4  opcode field
- in_rd  input  6  destination register field
- out_valid  output  1  head-of-buffer word valid
- out_ready  input  1  consumer accepts the head word
- out_instr  output  32  packed instruction
- out_rs  output  6  rs field of the head word
- out_rt  output  6  rt field of the head word
- err_clr  input  1  clears range_err
- range_err  output  1  sticky out-of-range flag
- enc_count  output  16  count of words emitted

## Operation
- Field split: rs = in_imm[11:6] and rt = in_imm[5:0]; no sign handling.
- Instruction format:
  - out_instr[31:28] = opcode
  - out_instr[27:22] = rd
  - out_instr[21:16] = rs
  - out_instr[15:10] = rt
  - out_instr[9:0] = 0
- Buffer:
  - Two-entry FIFO holding {instr, rs, rt}.
  - Occupancy states are EMPTY (0), ONE (1) and FULL (2).
  - The head entry always drives out_instr, out_rs and out_rt.
- Handshakes:
  - Push on in_valid & in_ready.
  - Pop on out_valid & out_ready.
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- State transitions:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push and pop together → ONE (new word becomes head on the next cycle).
  - FULL: pop → ONE. Push is impossible because in_ready = 0; there is no pass-through.
- out_valid never deasserts while out_ready = 0. The head entry holds stable until it is popped.
- enc_count increments on every pop and wraps 0xFFFF → 0x0000.
- range_err:
  - Set when a pushed in_imm has in_imm[31:12] != 0 (with ENC_RANGE_CHECK_EN; see Configuration).
  - Cleared by err_clr.
  - If set and clear happen in the same cycle, set wins.

## Timing
- Reset values (asynchronous):
  - state = EMPTY
  - out_valid = 0
  - in_ready = 1
  - out_instr = 0, out_rs = 0, out_rt = 0
  - range_err = 0
  - enc_count = 0
  - Both buffer entries zeroed.
- Latency: a push at edge N gives out_valid = 1 and valid fields after edge N, one cycle from acceptance. When the FIFO is empty, the block passes nothing combinationally from input to output.
- Throughput: one word per cycle when out_ready is held high.
- Reset asserted mid-operation discards buffered words immediately. enc_count does not count the discarded words.
- in_ready and out_valid depend only on state, with no combinational path from the inputs.

## Configuration
- Macro: ENC_RANGE_CHECK_EN.
- Defined:
  - A push with in_imm[31:12] != 0 is consumed (in_ready behaves normally).
  - The word is not written to the buffer and state does not change.
  - range_err is set.
  - enc_count is unaffected.
- Undefined:
  - Upper immediate bits are silently truncated and the word is enqueued normally.
  - range_err is tied to 0.
  - err_clr is ignored.

## Test plan
- Reset, then push imm=0x00000ABC, opcode=0x7, rd=5 with out_ready=1 → one cycle later out_valid=1, out_rs=0x2A, out_rt=0x3C, out_instr=0x716AF000; enc_count=1 after the pop.
- out_ready=0, push 3 words back-to-back → in_ready=0 after the second push; third word held at input. Raise out_ready → words emerge in order; third accepted once state leaves FULL.
- State ONE with push and pop in the same cycle → state stays ONE; next head is the newly pushed word; no word is lost or duplicated.
- With ENC_RANGE_CHECK_EN, push imm=0x00001000 → no output word, range_err=1. Pulse err_clr → range_err=0. Without the macro, the same push emits rs=0, rt=0 and range_err stays 0.
- Pop 65536 words → enc_count wraps to 0x0000.
- Assert rst_n low while FULL → out_valid=0, in_ready=1 and all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_rs_rt_encoder.sv
// Packs opcode/rd and a 12-bit immediate split into rs/rt into a 32-bit instruction word,
// delivered through a 2-entry valid/ready buffer. Optional range check: `ENC_RANGE_CHECK_EN.
module imm_rs_rt_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_opcode,
    input  logic [5:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [5:0]  out_rs,
    output logic [5:0]  out_rt,
    input  logic        err_clr,
    output logic        range_err,
    output logic [15:0] enc_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_push;
    logic        w_pop;
    logic        w_write;
    logic [43:0] w_new_entry;
    logic [43:0] r_head;
    logic [43:0] r_tail;
    logic [15:0] r_enc_count;

    // Entry layout: {instr[31:0], rs[5:0], rt[5:0]}
    assign w_new_entry = {in_opcode, in_rd, in_imm[11:6], in_imm[5:0], 10'd0,
                          in_imm[11:6], in_imm[5:0]};

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

`ifdef ENC_RANGE_CHECK_EN
    logic w_out_of_range;
    logic r_range_err;

    assign w_out_of_range = |in_imm[31:12];
    // Out-of-range requests are consumed but dropped; state and buffer stay put.
    assign w_write        = w_push & ~w_out_of_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (w_push && w_out_of_range) begin
            r_range_err <= 1'b1;
        end else if (err_clr) begin
            r_range_err <= 1'b0;
        end
    end

    assign range_err = r_range_err;
`else
    logic w_unused;

    assign w_write   = w_push;
    assign range_err = 1'b0;
    assign w_unused  = ^{err_clr, in_imm[31:12]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: begin
                if (w_write) begin
                    w_next_state = ONE;
                end
            end
            ONE: begin
                if (w_write && !w_pop) begin
                    w_next_state = FULL;
                end else if (!w_write && w_pop) begin
                    w_next_state = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_next_state = ONE;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (r_state != FULL);
        out_valid = (r_state != EMPTY);
    end

    // Head is always entry 0; a pop from FULL shifts the tail forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_write) begin
                        r_head <= w_new_entry;
                    end
                end
                ONE: begin
                    if (w_write && w_pop) begin
                        r_head <= w_new_entry;
                    end else if (w_write) begin
                        r_tail <= w_new_entry;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                    end
                end
                default: begin
                    r_head <= r_head;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_count <= 16'd0;
        end else if (w_pop) begin
            r_enc_count <= r_enc_count + 16'd1;
        end
    end

    assign out_instr = r_head[43:12];
    assign out_rs    = r_head[11:6];
    assign out_rt    = r_head[5:0];
    assign enc_count = r_enc_count;

endmodule

// File: tb/tb_imm_rs_rt_encoder.sv
// Directed self-checking bench for imm_rs_rt_encoder; expected words are hand-packed constants.
// Range-check expectations follow `ENC_RANGE_CHECK_EN when the bench is built with it.
module tb_imm_rs_rt_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [3:0]  in_opcode;
    logic [5:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_rs;
    logic [5:0]  out_rt;
    logic        err_clr;
    logic        range_err;
    logic [15:0] enc_count;

    int testsRun;
    int testsFailed;

    imm_rs_rt_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .err_clr   (err_clr),
        .range_err (range_err),
        .enc_count (enc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] imm,
                                 input logic [3:0] opcode, input logic [5:0] rd);
        in_valid  = valid;
        in_imm    = imm;
        in_opcode = opcode;
        in_rd     = rd;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        err_clr     = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("rst_instr",     out_instr,          32'h0);
        checkOutput("rst_rs",        {26'd0, out_rs},    32'h0);
        checkOutput("rst_rt",        {26'd0, out_rt},    32'h0);
        checkOutput("rst_range_err", {31'd0, range_err}, 32'd0);
        checkOutput("rst_enc_count", {16'd0, enc_count}, 32'd0);
        stepCycle();
        rst_n = 1'b1;

        // Single word, 1-cycle latency, then popped
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_0ABC, 4'h7, 6'd5);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t1_rs",    {26'd0, out_rs},    32'h2A);
        checkOutput("t1_rt",    {26'd0, out_rt},    32'h3C);
        checkOutput("t1_instr", out_instr,          32'h716A_F000);
        stepCycle();
        checkOutput("t1_count", {16'd0, enc_count}, 32'd1);
        checkOutput("t1_empty", {31'd0, out_valid}, 32'd0);

        // Back-to-back pushes into a stalled consumer
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_0041, 4'h1, 6'h01);
        stepCycle();
        checkOutput("t2_ready_one", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'h0000_0FFF, 4'hF, 6'h3F);
        stepCycle();
        checkOutput("t2_ready_full", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, 32'h0000_0555, 4'h2, 6'h0A);
        stepCycle();
        checkOutput("t2_hold_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("t2_hold_head",  out_instr,         32'h1041_0400);
        checkOutput("t2_hold_count", {16'd0, enc_count}, 32'd1);
        out_ready = 1'b1;
        stepCycle();
        checkOutput("t2_head_b",  out_instr,          32'hFFFF_FC00);
        checkOutput("t2_ready_b", {31'd0, in_ready},  32'd1);
        checkOutput("t2_count_b", {16'd0, enc_count}, 32'd2);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        checkOutput("t3_valid_c", {31'd0, out_valid}, 32'd1);
        checkOutput("t3_head_c",  out_instr,          32'h2295_5400);
        checkOutput("t3_rs_c",    {26'd0, out_rs},    32'h15);
        checkOutput("t3_count_c", {16'd0, enc_count}, 32'd3);
        stepCycle();
        checkOutput("t3_empty", {31'd0, out_valid}, 32'd0);
        checkOutput("t3_count", {16'd0, enc_count}, 32'd4);

        // Immediate above 12 bits
`ifdef ENC_RANGE_CHECK_EN
        applyStimulus(1'b1, 32'h0000_1000, 4'h3, 6'h02);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        checkOutput("t4_err_set",  {31'd0, range_err}, 32'd1);
        checkOutput("t4_no_word",  {31'd0, out_valid}, 32'd0);
        stepCycle();
        checkOutput("t4_count",    {16'd0, enc_count}, 32'd4);
        err_clr = 1'b1;
        stepCycle();
        err_clr = 1'b0;
        checkOutput("t4_err_clr",  {31'd0, range_err}, 32'd0);
        applyStimulus(1'b1, 32'h8000_0000, 4'h3, 6'h02);
        err_clr = 1'b1;
        stepCycle();
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        err_clr = 1'b0;
        checkOutput("t4_set_wins", {31'd0, range_err}, 32'd1);
        checkOutput("t4_no_word2", {31'd0, out_valid}, 32'd0);
`else
        applyStimulus(1'b1, 32'h0000_1000, 4'h3, 6'h02);
        err_clr = 1'b1;
        stepCycle();
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        err_clr = 1'b0;
        checkOutput("t4_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t4_rs",    {26'd0, out_rs},    32'h0);
        checkOutput("t4_rt",    {26'd0, out_rt},    32'h0);
        checkOutput("t4_instr", out_instr,          32'h3080_0000);
        checkOutput("t4_err",   {31'd0, range_err}, 32'd0);
        stepCycle();
        checkOutput("t4_count", {16'd0, enc_count}, 32'd5);
`endif

        // Counter wrap under full-rate streaming
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        checkOutput("t5_count_rst", {16'd0, enc_count}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, i & 32'hFFF, 4'h4, 6'h04);
            stepCycle();
        end
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        checkOutput("t5_count_ffff", {16'd0, enc_count}, 32'hFFFF);
        checkOutput("t5_last_rt",    {26'd0, out_rt},    32'h3F);
        stepCycle();
        checkOutput("t5_count_wrap", {16'd0, enc_count}, 32'h0);
        checkOutput("t5_empty",      {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_0ABC, 4'h7, 6'd5);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 32'h0, 4'h0, 6'h0);
        checkOutput("t6_full", {31'd0, in_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_ready", {31'd0, in_ready},  32'd1);
        checkOutput("t6_instr", out_instr,          32'h0);
        checkOutput("t6_rs",    {26'd0, out_rs},    32'h0);
        checkOutput("t6_rt",    {26'd0, out_rt},    32'h0);
        checkOutput("t6_count", {16'd0, enc_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
